// File: rtl/sseg_pkg.sv
// Shared constants, segment table and types for the seven-segment scan controller.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned VAL_W      = 4;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0]      SSEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = 8'hFF;

    // Active-low patterns, bit 6 = a ... bit 0 = g; listed F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef struct packed {
        logic             dp;
        logic [VAL_W-1:0] val;
    } digit_entry_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [VAL_W-1:0] value_i,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_PATTERNS[value_i];

endmodule

// File: rtl/sseg_scan_controller.sv
// Eight-digit multiplexed display scanner with blanking gap, enable and blink masks.
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 41666,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [4:0]            wr_data,
    input  logic [NUM_DIGITS-1:0] enable_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic                  frame_start,
    output logic [SEG_W-1:0]      sseg,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned SLOT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    scan_state_e           state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      digit_q, digit_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  blink_q, blink_d;
    digit_entry_t          dbuf_q [NUM_DIGITS];

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      sseg_q, sseg_d;
    logic                  dp_q, dp_d;
    logic                  fs_q, fs_d;

    digit_entry_t          cur_entry;
    logic [SEG_W-1:0]      cur_seg;
    logic                  lit;
    logic                  slot_wrap;

    assign cur_entry = dbuf_q[digit_q];
    assign lit       = enable_mask[digit_q] & ~(blink_mask[digit_q] & blink_q);
    assign slot_wrap = (slot_q == SLOT_W'(DIGIT_CYCLES - 1));

    hex_to_sseg u_hex (
        .value_i (cur_entry.val),
        .seg_c   (cur_seg)
    );

    // Digit buffer: game-logic writes always land, last write wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dbuf_q[i] <= '0;
            end
        end else if (wr_en) begin
            dbuf_q[wr_addr] <= digit_entry_t'(wr_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            slot_q  <= '0;
            digit_q <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
            an_q    <= AN_OFF;
            sseg_q  <= SSEG_OFF;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q + SLOT_W'(1);
        digit_d = digit_q;
        frame_d = frame_q;
        blink_d = blink_q;
        an_d    = AN_OFF;
        sseg_d  = SSEG_OFF;
        dp_d    = 1'b1;
        fs_d    = (state_q == BLANK) && (slot_q == '0) && (digit_q == '0);

        // Slot wrap advances the digit; wrapping past digit 7 closes a frame.
        if (slot_wrap) begin
            slot_d  = '0;
            digit_d = digit_q + IDX_W'(1);
            if (digit_q == IDX_W'(NUM_DIGITS - 1)) begin
                if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + FRAME_W'(1);
                end
            end
        end

        case (state_q)
            BLANK: begin
                if (slot_q == SLOT_W'(BLANK_CYCLES - 1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_wrap) begin
                    state_d = BLANK;
                end
                if (lit) begin
                    an_d   = ~(NUM_DIGITS'(1) << digit_q);
                    sseg_d = cur_seg;
                    dp_d   = ~cur_entry.dp;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign DP          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Randomised bench for sseg_scan_controller against a time-indexed display model.
module tb_sseg_scan_controller;

    localparam int DC    = 10;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DC;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] enable_mask;
    logic [7:0] blink_mask;
    logic       frame_start;
    logic [6:0] sseg;
    logic       DP;
    logic [7:0] an;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;
    logic [4:0] mbuf [8];

    int         m_slot, m_k, m_ph, m_zeros;
    logic       m_lit;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    logic [4:0] m_ent;

    always #5 clk = ~clk;

    sseg_scan_controller #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .enable_mask (enable_mask),
        .blink_mask  (blink_mask),
        .frame_start (frame_start),
        .sseg        (sseg),
        .DP          (DP),
        .an          (an)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h01;  4'h1: return 7'h4F;
            4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;
            4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;
            4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;
            4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    // Every cycle: what the pins must show follows from time since release, masks and buffer.
    always @(posedge clk) begin
        if (!reset_n) begin
            t = 0;
            for (int i = 0; i < 8; i++) mbuf[i] = 5'h00;
        end else begin
            m_slot = t % DC;
            m_k    = (t / DC) % 8;
            m_ph   = (t / (FRAME * BF)) % 2;
            m_lit  = (m_slot >= BC) && enable_mask[m_k] && !(blink_mask[m_k] && (m_ph == 1));
            m_ent  = mbuf[m_k];
            e_an   = m_lit ? ~(8'd1 << m_k) : 8'hFF;
            e_seg  = m_lit ? hex_seg(m_ent[3:0]) : 7'h7F;
            e_dp   = m_lit ? ~m_ent[4] : 1'b1;
            e_fs   = ((t % FRAME) == 0);
            if (wr_en) mbuf[wr_addr] = wr_data;
            t++;
            #1;
            if (reset_n) begin
                cmp("an", an, e_an);
                cmp("sseg", sseg, e_seg);
                cmp("dp", DP, e_dp);
                cmp("frame_start", frame_start, e_fs);
                m_zeros = 0;
                for (int i = 0; i < 8; i++) if (!an[i]) m_zeros++;
                cmp("an_single_low", m_zeros <= 1, 1);
            end
        end
    end

    task automatic wait_next(input int m, input int v);
        int n;
        n = 0;
        while ((t % m) != v && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_bound: t=%0d never reached %0d mod %0d", t, v, m);
        end
    endtask

    task automatic at_t(input int m, input int v);
        wait_next(m, v);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 3'd0;
        wr_data     = 5'h00;
        enable_mask = 8'hFF;
        blink_mask  = 8'h00;

        repeat (3) @(posedge clk);
        #2;
        cmp("rst_an", an, 8'hFF);
        cmp("rst_sseg", sseg, 7'h7F);
        cmp("rst_dp", DP, 1'b1);
        cmp("rst_fs", frame_start, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;

        at_t(FRAME, 1);
        cmp("lit_blank1", an, 8'hFF);
        at_t(FRAME, 2);
        cmp("first_lit_an", an, 8'hFE);
        cmp("first_lit_sseg", sseg, 7'h01);
        at_t(FRAME, 75);
        cmp("digit7_an", an, 8'h7F);
        at_t(FRAME, 0);
        cmp("frame_pulse", frame_start, 1'b1);

        // Write digit 3 while it is being driven.
        wait_next(FRAME, 33);
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 5'h18;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        cmp("wr_live_an", an, 8'hF7);
        cmp("wr_live_sseg", sseg, 7'h00);
        cmp("wr_live_dp", DP, 1'b0);

        wait_next(FRAME, 79);
        enable_mask = 8'hFE;
        at_t(FRAME, 5);
        cmp("en_dark_d0", an, 8'hFF);
        at_t(FRAME, 15);
        cmp("en_d1", an, 8'hFD);
        at_t(FRAME, 35);
        cmp("en_d3_sseg", sseg, 7'h00);

        wait_next(FRAME, 79);
        enable_mask = 8'hFF;
        blink_mask  = 8'h01;
        at_t(2 * FRAME * BF, FRAME * BF + 5);
        cmp("blink_off_d0", an, 8'hFF);
        at_t(2 * FRAME * BF, 5);
        cmp("blink_on_d0", an, 8'hFE);

        // Asynchronous reset in the middle of digit 5's drive window.
        at_t(FRAME, 55);
        cmp("pre_rst_d5", an, 8'hDF);
        #1;
        reset_n = 1'b0;
        #1;
        cmp("async_an", an, 8'hFF);
        cmp("async_sseg", sseg, 7'h7F);
        cmp("async_dp", DP, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        at_t(FRAME, 2);
        cmp("restart_an", an, 8'hFE);
        cmp("restart_sseg", sseg, 7'h01);
        at_t(FRAME, 35);
        cmp("buf_cleared", sseg, 7'h01);

        repeat (10000) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                enable_mask = 8'($urandom);
                blink_mask  = 8'($urandom);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
